// File: rtl/exp_taylor_iter.sv
// rtl/exp_taylor_iter.sv - iterative fixed-point e^x by truncated Taylor series, one term per clock
module exp_taylor_iter #(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 16,
  parameter int N_TERMS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  localparam int ACC_W  = 2 * WIDTH;
  localparam int P1_W   = 2 * ACC_W;
  localparam int P2_W   = 2 * ACC_W + FRAC + 2;
  localparam int KW     = 7;
  localparam int RW     = FRAC + 1;

  localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1) << FRAC;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Reciprocal table floor(2^FRAC / k); entry 0 is never used.
  function automatic logic [N_TERMS*RW-1:0] build_recip();
    logic [N_TERMS*RW-1:0] tbl;
    tbl = '0;
    for (int k = 1; k < N_TERMS; k++) begin
      tbl[k*RW +: RW] = RW'((64'd1 << FRAC) / 64'(k));
    end
    return tbl;
  endfunction

  localparam logic [N_TERMS*RW-1:0] RECIP_TBL = build_recip();

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  x_reg_q, x_reg_d;
  logic signed [ACC_W-1:0]  term_q, term_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     sat_q, sat_d;
  logic [WIDTH-1:0]         out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic [RW-1:0]            recip;
  logic signed [P1_W-1:0]   term_ext, x_ext, prod1, p;
  logic signed [P2_W-1:0]   p_ext, recip_ext, prod2, t_wide;
  logic                     t_ovf, sum_ovf;
  logic signed [ACC_W-1:0]  t_sat, sum_next;
  logic signed [ACC_W:0]    sum_wide;
  logic                     res_neg, res_big;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Datapath for one series step: full-width products, floor shifts, saturation to ACC_W.
  always_comb begin
    recip     = RECIP_TBL[int'(k_q)*RW +: RW];
    term_ext  = {{(P1_W-ACC_W){term_q[ACC_W-1]}}, term_q};
    x_ext     = {{(P1_W-ACC_W){x_reg_q[ACC_W-1]}}, x_reg_q};
    prod1     = term_ext * x_ext;
    p         = prod1 >>> FRAC;
    p_ext     = {{(P2_W-P1_W){p[P1_W-1]}}, p};
    recip_ext = {{(P2_W-RW){1'b0}}, recip};
    prod2     = p_ext * recip_ext;
    t_wide    = prod2 >>> FRAC;
    t_ovf     = (t_wide[P2_W-1:ACC_W-1] != {(P2_W-ACC_W+1){t_wide[P2_W-1]}});
    t_sat     = t_ovf ? (t_wide[P2_W-1] ? ACC_MIN : ACC_MAX) : t_wide[ACC_W-1:0];
    sum_wide  = {sum_q[ACC_W-1], sum_q} + {t_sat[ACC_W-1], t_sat};
    sum_ovf   = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
    sum_next  = sum_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
    res_neg   = sum_next[ACC_W-1];
    res_big   = |sum_next[ACC_W-2:WIDTH];
  end

  // Next-state and register updates for the IDLE -> ITER -> DONE sequence.
  always_comb begin
    state_d    = state_q;
    x_reg_d    = x_reg_q;
    term_d     = term_q;
    sum_d      = sum_q;
    k_d        = k_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_reg_d = {{(ACC_W-WIDTH){x_in[WIDTH-1]}}, x_in};
          term_d  = ONE;
          sum_d   = ONE;
          k_d     = KW'(1);
          sat_d   = 1'b0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        term_d = t_sat;
        sum_d  = sum_next;
        sat_d  = sat_q | t_ovf | sum_ovf;
        k_d    = k_q + KW'(1);
        if (k_q == KW'(N_TERMS-1)) begin
          // Result is captured here so it stays stable under backpressure.
          out_data_d = res_neg ? '0 : (res_big ? '1 : sum_next[WIDTH-1:0]);
          out_sat_d  = sat_q | t_ovf | sum_ovf | res_neg | res_big;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous reset clearing every internal register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_reg_q    <= '0;
      term_q     <= '0;
      sum_q      <= '0;
      k_q        <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_reg_q    <= x_reg_d;
      term_q     <= term_d;
      sum_q      <= sum_d;
      k_q        <= k_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_exp_taylor_iter.sv
// tb/tb_exp_taylor_iter.sv - scoreboard bench for exp_taylor_iter
module tb_exp_taylor_iter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        sat;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  exp_taylor_iter #(.WIDTH(32), .FRAC(16), .N_TERMS(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare every accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1'b0, 64'(out_data), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("data_op%0d", mon_e.id),
              (out_data >= mon_e.lo) && (out_data <= mon_e.hi), 64'(out_data), 64'(mon_e.lo));
        check($sformatf("sat_op%0d", mon_e.id), out_sat == mon_e.sat, 64'(out_sat), 64'(mon_e.sat));
      end
    end
  end

  task automatic run_op(input logic [31:0] x, input logic [31:0] lo, input logic [31:0] hi,
                        input logic sat, input int id, input bit bp);
    int guard;
    int lat;
    exp_t e;
    e.lo = lo; e.hi = hi; e.sat = sat; e.id = id;
    sb.push_back(e);
    out_ready = !bp;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check($sformatf("idle_before_op%0d", id), in_ready, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = 32'hDEADBEEF;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("latency_op%0d", id), lat == 11, 64'(lat), 64'd11);
    if (bp) begin
      in_valid = 1'b1;
      x_in     = 32'h00140000;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check($sformatf("bp_data_c%0d", i), (out_data >= lo) && (out_data <= hi), 64'(out_data), 64'(lo));
        check($sformatf("bp_valid_c%0d", i), out_valid == 1'b1, 64'(out_valid), 64'd1);
        check($sformatf("bp_in_ready_c%0d", i), in_ready == 1'b0, 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check($sformatf("in_ready_after_op%0d", id), in_ready == 1'b1, 64'(in_ready), 64'd1);
    check($sformatf("valid_drop_op%0d", id), out_valid == 1'b0, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = 32'h0;
    #12;
    check("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
    check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
    check("rst_busy", busy == 1'b0, 64'(busy), 64'd0);
    check("rst_out_data", out_data == 32'h0, 64'(out_data), 64'd0);
    check("rst_out_sat", out_sat == 1'b0, 64'(out_sat), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);

    run_op(32'h00000000, 32'h00010000,      32'h00010000,      1'b0, 0, 1'b0);
    run_op(32'h00010000, 32'h0002B7E1 - 12, 32'h0002B7E1,      1'b0, 1, 1'b0);
    run_op(32'hFFFF0000, 32'h00005E2D - 12, 32'h00005E2D + 12, 1'b0, 2, 1'b0);
    run_op(32'h00140000, 32'hFFFFFFFF,      32'hFFFFFFFF,      1'b1, 3, 1'b0);
    run_op(32'h00008000, 32'h0001A612 - 12, 32'h0001A612 + 12, 1'b0, 4, 1'b1);

    // Abort an operation with reset while k = 5.
    in_valid = 1'b1;
    x_in     = 32'h00010000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
    check("abort_busy", busy == 1'b0, 64'(busy), 64'd0);
    check("abort_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(32'h00000000, 32'h00010000, 32'h00010000, 1'b0, 5, 1'b0);

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size() == 0, 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
